// File: rtl/huffman_stream_decoder_if.sv
// huffman_stream_decoder_if
//   Bundles the signals of huffman_stream_decoder other than clk and rst:
//   the input word stream, the output symbol stream, the status flags and
//   the table programming port.
//   Modports:
//     master : stream source, symbol sink and table programmer (drives the
//              in_* words, out_ready and cfg_*; observes everything else)
//     slave  : the decoder itself
//   Signals:
//     in_data[IN_W]   code bits, MSB first      in_valid / in_ready  word handshake
//     in_last         word ends the stream      in_nbits[NB_W]       valid bits in last word (0 = IN_W)
//     out_sym[SYM_W]  decoded symbol            out_len[LEN_W]       its code length
//     out_valid / out_ready                     symbol handshake
//     done            end-of-stream pulse       err                  sticky illegal-code flag
//     busy            decoder holds state       cfg_we/sel/addr/data table write port
interface huffman_stream_decoder_if #(
  parameter int IN_W    = 8,
  parameter int MAX_LEN = 8,
  parameter int SYM_W   = 4,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int NB_W    = $clog2(IN_W + 1)
);
  logic [IN_W-1:0]    in_data;
  logic               in_valid;
  logic               in_last;
  logic [NB_W-1:0]    in_nbits;
  logic               in_ready;
  logic [SYM_W-1:0]   out_sym;
  logic [LEN_W-1:0]   out_len;
  logic               out_valid;
  logic               out_ready;
  logic               done;
  logic               err;
  logic               busy;
  logic               cfg_we;
  logic [1:0]         cfg_sel;
  logic [SYM_W-1:0]   cfg_addr;
  logic [MAX_LEN-1:0] cfg_data;

  modport master (
    output in_data, in_valid, in_last, in_nbits, out_ready,
           cfg_we, cfg_sel, cfg_addr, cfg_data,
    input  in_ready, out_sym, out_len, out_valid, done, err, busy
  );

  modport slave (
    input  in_data, in_valid, in_last, in_nbits, out_ready,
           cfg_we, cfg_sel, cfg_addr, cfg_data,
    output in_ready, out_sym, out_len, out_valid, done, err, busy
  );
endinterface

// File: rtl/huffman_stream_decoder.sv
// huffman_stream_decoder
//   Canonical-Huffman stream decoder. MSB-first packed words are collected
//   into a left-aligned bit buffer; the head of the buffer is matched against
//   a runtime-programmable canonical table (first_code / count / base per
//   length, plus a symbol table) and one symbol is emitted per handshake.
//   Illegal codes raise a sticky err that only reset clears; the end of a
//   stream is reported with a one-cycle done pulse.
//   Build option: define HUFF_PARALLEL_EN to resolve all code lengths in one
//   cycle (priority encoder, smallest length wins). Without it the search
//   checks one length per cycle starting at 1.
//   Ports:
//     clk  clock
//     rst  asynchronous, active-low reset
//     bus  huffman_stream_decoder_if.slave (word input, symbol output,
//          done/err/busy status, table write port)
//   All outputs come straight from registers.
module huffman_stream_decoder #(
  parameter int IN_W    = 8,
  parameter int MAX_LEN = 8,
  parameter int SYM_W   = 4
) (
  input logic                     clk,
  input logic                     rst,
  huffman_stream_decoder_if.slave bus
);
  localparam int BUF_W  = IN_W + MAX_LEN;
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int NB_W   = $clog2(IN_W + 1);
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int NSYM   = 1 << SYM_W;

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_ERROR  = 1'b1;

  // Tables, indexed by length-1 (or symbol index for sym_tab_r)
  logic [MAX_LEN-1:0] first_code_r [MAX_LEN];
  logic [SYM_W:0]     count_r      [MAX_LEN];
  logic [SYM_W-1:0]   base_r       [MAX_LEN];
  logic [SYM_W-1:0]   sym_tab_r    [NSYM];

  // Datapath / control state
  logic [BUF_W-1:0]  bits_r,      bits_nxt_s;
  logic [FILL_W-1:0] fill_r,      fill_nxt_s;
  logic              last_seen_r, last_seen_nxt_s;
  logic [0:0]        state_r,     state_nxt_s;
  logic              err_r,       err_nxt_s;
  logic [LEN_W-1:0]  cur_l_r,     cur_l_nxt_s;
  logic [SYM_W-1:0]  out_sym_r,   out_sym_nxt_s;
  logic [LEN_W-1:0]  out_len_r,   out_len_nxt_s;
  logic              out_valid_r, out_valid_nxt_s;
  logic              done_r,      done_nxt_s;
  logic              in_ready_r,  in_ready_nxt_s;
  logic              busy_r,      busy_nxt_s;

  // Per-length match results
  logic [MAX_LEN-1:0] win_s;
  logic [MAX_LEN-1:0] code_s [MAX_LEN];
  logic [MAX_LEN-1:0] diff_s [MAX_LEN];
  logic [SYM_W-1:0]   idx_s  [MAX_LEN];
  logic [MAX_LEN-1:0] match_s;

  // Selected lookup outcome for this cycle
  logic              hit_s;
  logic              grow_s;
  logic [LEN_W-1:0]  hit_len_s;
  logic [SYM_W-1:0]  hit_idx_s;

  // Next-state helpers
  logic              lookup_ok_s;
  logic              accept_s;
  logic [FILL_W-1:0] shift_s;
  logic [FILL_W-1:0] fill_sh_s;
  logic [BUF_W-1:0]  bits_sh_s;
  logic [FILL_W-1:0] nb_s;
  logic [NB_W-1:0]   nb_in_s;
  logic [IN_W-1:0]   word_s;

  assign nb_in_s = bus.in_nbits;

  // Extract the L-bit head of the buffer for every L and test it against the table
  always_comb begin
    win_s = bits_r[BUF_W-1 -: MAX_LEN];
    for (int i = 0; i < MAX_LEN; i++) begin
      code_s[i]  = win_s >> (MAX_LEN - 1 - i);
      diff_s[i]  = code_s[i] - first_code_r[i];
      // diff is only meaningful once code >= first_code, so no wrap can leak through
      match_s[i] = (FILL_W'(i + 1) <= fill_r) &&
                   (count_r[i] != {(SYM_W+1){1'b0}}) &&
                   (code_s[i] >= first_code_r[i]) &&
                   (diff_s[i] < MAX_LEN'(count_r[i]));
      idx_s[i]   = base_r[i] + diff_s[i][SYM_W-1:0];
    end
  end

  // Choose which length is resolved this cycle
  always_comb begin
    hit_s     = 1'b0;
    grow_s    = 1'b0;
    hit_len_s = {LEN_W{1'b0}};
    hit_idx_s = {SYM_W{1'b0}};
`ifdef HUFF_PARALLEL_EN
    // Descending scan: the last assignment standing is the smallest match
    for (int i = MAX_LEN - 1; i >= 0; i--) begin
      if (match_s[i]) begin
        hit_s     = 1'b1;
        hit_len_s = LEN_W'(i + 1);
        hit_idx_s = idx_s[i];
      end else begin
        hit_s     = hit_s;
      end
    end
`else
    for (int i = 0; i < MAX_LEN; i++) begin
      if (cur_l_r == LEN_W'(i + 1)) begin
        hit_s     = match_s[i];
        hit_idx_s = idx_s[i];
      end else begin
        hit_idx_s = hit_idx_s;
      end
    end
    hit_len_s = cur_l_r;
    // Only try a longer code if one exists and enough bits are buffered for it
    grow_s    = (cur_l_r < LEN_W'(MAX_LEN)) && (FILL_W'(cur_l_r) < fill_r);
`endif
  end

  // Next-state computation for buffer, search, output register and status
  always_comb begin
    state_nxt_s   = state_r;
    err_nxt_s     = err_r;
    cur_l_nxt_s   = cur_l_r;
    out_sym_nxt_s = out_sym_r;
    out_len_nxt_s = out_len_r;
    shift_s       = {FILL_W{1'b0}};

    lookup_ok_s = (state_r == ST_SEARCH) &&
                  (!out_valid_r || bus.out_ready) &&
                  (fill_r != {FILL_W{1'b0}}) &&
                  ((fill_r >= FILL_W'(MAX_LEN)) || last_seen_r);
    accept_s    = in_ready_r && bus.in_valid;

    // The pending symbol completes its handshake even in ERROR
    if (out_valid_r && bus.out_ready) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end

    if (lookup_ok_s) begin
      if (hit_s) begin
        out_sym_nxt_s   = sym_tab_r[hit_idx_s];
        out_len_nxt_s   = hit_len_s;
        out_valid_nxt_s = 1'b1;
        shift_s         = FILL_W'(hit_len_s);
        cur_l_nxt_s     = LEN_W'(1);
      end else if (grow_s) begin
        cur_l_nxt_s     = cur_l_r + LEN_W'(1);
      end else begin
        state_nxt_s     = ST_ERROR;
        err_nxt_s       = 1'b1;
      end
    end else begin
      cur_l_nxt_s = cur_l_r;
    end

    // Consume first, then append behind whatever is left
    bits_sh_s = bits_r << shift_s;
    fill_sh_s = fill_r - shift_s;

    if (bus.in_last && (nb_in_s != {NB_W{1'b0}}) && (nb_in_s < NB_W'(IN_W))) begin
      nb_s = FILL_W'(nb_in_s);
    end else begin
      nb_s = FILL_W'(IN_W);
    end
    // Clear bits past the valid count so later appends can simply OR in
    word_s = bus.in_data & ~({IN_W{1'b1}} >> nb_s);

    if (accept_s) begin
      bits_nxt_s      = bits_sh_s | ({word_s, {MAX_LEN{1'b0}}} >> fill_sh_s);
      fill_nxt_s      = fill_sh_s + nb_s;
      last_seen_nxt_s = bus.in_last;
    end else begin
      bits_nxt_s      = bits_sh_s;
      fill_nxt_s      = fill_sh_s;
      last_seen_nxt_s = last_seen_r;
    end

    // Stream fully drained: nothing buffered and the last symbol is gone or leaving
    if (last_seen_r && (fill_r == {FILL_W{1'b0}}) && !err_r &&
        (!out_valid_r || bus.out_ready)) begin
      done_nxt_s      = 1'b1;
      last_seen_nxt_s = 1'b0;
    end else begin
      done_nxt_s      = 1'b0;
    end

    in_ready_nxt_s = !err_nxt_s && !last_seen_nxt_s && (fill_nxt_s <= FILL_W'(MAX_LEN));
    busy_nxt_s     = (fill_nxt_s != {FILL_W{1'b0}}) || out_valid_nxt_s ||
                     last_seen_nxt_s || (cur_l_nxt_s != LEN_W'(1));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bits_r      <= {BUF_W{1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      last_seen_r <= 1'b0;
      state_r     <= ST_SEARCH;
      err_r       <= 1'b0;
      cur_l_r     <= LEN_W'(1);
      out_sym_r   <= {SYM_W{1'b0}};
      out_len_r   <= {LEN_W{1'b0}};
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      bits_r      <= bits_nxt_s;
      fill_r      <= fill_nxt_s;
      last_seen_r <= last_seen_nxt_s;
      state_r     <= state_nxt_s;
      err_r       <= err_nxt_s;
      cur_l_r     <= cur_l_nxt_s;
      out_sym_r   <= out_sym_nxt_s;
      out_len_r   <= out_len_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      done_r      <= done_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // Table programming, accepted only while the decoder is idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        first_code_r[i] <= {MAX_LEN{1'b0}};
        count_r[i]      <= {(SYM_W+1){1'b0}};
        base_r[i]       <= {SYM_W{1'b0}};
      end
      for (int i = 0; i < NSYM; i++) begin
        sym_tab_r[i] <= {SYM_W{1'b0}};
      end
    end else if (bus.cfg_we && !busy_r) begin
      case (bus.cfg_sel)
        2'd0: begin
          for (int i = 0; i < MAX_LEN; i++)
            if (bus.cfg_addr == SYM_W'(i)) first_code_r[i] <= bus.cfg_data;
        end
        2'd1: begin
          for (int i = 0; i < MAX_LEN; i++)
            if (bus.cfg_addr == SYM_W'(i)) count_r[i] <= bus.cfg_data[SYM_W:0];
        end
        2'd2: begin
          for (int i = 0; i < MAX_LEN; i++)
            if (bus.cfg_addr == SYM_W'(i)) base_r[i] <= bus.cfg_data[SYM_W-1:0];
        end
        2'd3: begin
          sym_tab_r[bus.cfg_addr] <= bus.cfg_data[SYM_W-1:0];
        end
        default: begin
          sym_tab_r[bus.cfg_addr] <= sym_tab_r[bus.cfg_addr];
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_sym   = out_sym_r;
  assign bus.out_len   = out_len_r;
  assign bus.out_valid = out_valid_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_huffman_stream_decoder.sv
// tb_huffman_stream_decoder
//   Directed bench for huffman_stream_decoder using the table
//   0/10/110/111 -> 5/9/3/12. Inputs change 2 time units after a rising
//   edge; outputs and handshakes are observed at the falling edge.
module tb_huffman_stream_decoder;
  localparam int IN_W    = 8;
  localparam int MAX_LEN = 8;
  localparam int SYM_W   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  huffman_stream_decoder_if #(.IN_W(IN_W), .MAX_LEN(MAX_LEN), .SYM_W(SYM_W)) bus ();

  huffman_stream_decoder #(.IN_W(IN_W), .MAX_LEN(MAX_LEN), .SYM_W(SYM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int sym_q[$];
  int len_q[$];
  int done_total = 0;

  int exp_sym[5] = '{5, 9, 3, 12, 5};
  int exp_len[5] = '{1, 2, 3, 3, 1};

  // Record every completed symbol handshake and every done pulse
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      sym_q.push_back(int'(bus.out_sym));
      len_q.push_back(int'(bus.out_len));
    end
    if (bus.done) done_total++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [3:0] addr, input logic [7:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    step(1);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic load_table(input logic [7:0] sym0);
    cfg_write(2'd0, 4'd0, 8'd0);
    cfg_write(2'd0, 4'd1, 8'd2);
    cfg_write(2'd0, 4'd2, 8'd6);
    cfg_write(2'd1, 4'd0, 8'd1);
    cfg_write(2'd1, 4'd1, 8'd1);
    cfg_write(2'd1, 4'd2, 8'd2);
    cfg_write(2'd2, 4'd0, 8'd0);
    cfg_write(2'd2, 4'd1, 8'd1);
    cfg_write(2'd2, 4'd2, 8'd2);
    cfg_write(2'd3, 4'd0, sym0);
    cfg_write(2'd3, 4'd1, 8'd9);
    cfg_write(2'd3, 4'd2, 8'd3);
    cfg_write(2'd3, 4'd3, 8'd12);
  endtask

  // Present one word and hold it until the edge that accepts it
  task automatic send(input string tag, input logic [7:0] data, input logic last, input logic [3:0] nb);
    logic acc;
    acc          = 1'b0;
    bus.in_data  = data;
    bus.in_last  = last;
    bus.in_nbits = nb;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk({tag, "_accept"}, 32'(acc), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int dbase);
    for (int k = 0; k < 200; k++) begin
      if (done_total != dbase) break;
      step(1);
    end
    step(3);
    chk({tag, "_done_once"}, 32'(done_total - dbase), 32'd1);
  endtask

  task automatic wait_err(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (bus.err) break;
      step(1);
    end
  endtask

  task automatic check_seq(input string tag, input int base);
    chk({tag, "_count"}, 32'(sym_q.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < sym_q.size()) begin
        chk($sformatf("%s_sym%0d", tag, i), 32'(sym_q[base + i]), 32'(exp_sym[i]));
        chk($sformatf("%s_len%0d", tag, i), 32'(len_q[base + i]), 32'(exp_len[i]));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_sym"},   32'(bus.out_sym),   32'd0);
    chk({tag, "_out_len"},   32'(bus.out_len),   32'd0);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
    chk({tag, "_err"},       32'(bus.err),       32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    int base;
    int dbase;
    int lat;
    int exp_lat;

    rst          = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_nbits = 4'd0;
    bus.out_ready = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_sel  = 2'd0;
    bus.cfg_addr = 4'd0;
    bus.cfg_data = 8'h00;

    // Reset state
    step(2);
    check_reset_outputs("reset");
    rst = 1'b1;
    step(2);
    load_table(8'd5);

    // Nominal decode: 0|10|110|111|0
    bus.out_ready = 1'b1;
    base  = sym_q.size();
    dbase = done_total;
    send("s1_w0", 8'h5B, 1'b0, 4'd0);
    send("s1_w1", 8'h80, 1'b1, 4'd2);
    wait_done("s1", dbase);
    check_seq("s1", base);
    chk("s1_err",      32'(bus.err),      32'd0);
    chk("s1_busy",     32'(bus.busy),     32'd0);
    chk("s1_in_ready", 32'(bus.in_ready), 32'd1);

    // Backpressure: first symbol held for 5 cycles
    bus.out_ready = 1'b0;
    base  = sym_q.size();
    dbase = done_total;
    send("s3_w0", 8'h5B, 1'b0, 4'd0);
    send("s3_w1", 8'h80, 1'b1, 4'd2);
    for (int k = 0; k < 40; k++) begin
      if (bus.out_valid) break;
      step(1);
    end
    for (int k = 0; k < 5; k++) begin
      chk("s3_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("s3_hold_sym",   32'(bus.out_sym),   32'd5);
      chk("s3_hold_len",   32'(bus.out_len),   32'd1);
      step(1);
    end
    bus.out_ready = 1'b1;
    wait_done("s3", dbase);
    check_seq("s3", base);

    // Latency of code 111 counted from the accepting edge
`ifdef HUFF_PARALLEL_EN
    exp_lat = 1;
`else
    exp_lat = 3;
`endif
    base  = sym_q.size();
    dbase = done_total;
    send("s4_w0", 8'hE0, 1'b1, 4'd3);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step(1);
      lat++;
    end
    chk("s4_latency", 32'(lat),         32'(exp_lat));
    chk("s4_sym",     32'(bus.out_sym), 32'd12);
    chk("s4_len",     32'(bus.out_len), 32'd3);
    wait_done("s4", dbase);
    chk("s4_count", 32'(sym_q.size() - base), 32'd1);

    // Config gating: write while busy is dropped, write while idle lands
    bus.out_ready = 1'b0;
    base  = sym_q.size();
    dbase = done_total;
    send("s5_w0", 8'h00, 1'b1, 4'd1);
    chk("s5_busy", 32'(bus.busy), 32'd1);
    cfg_write(2'd3, 4'd0, 8'd7);
    bus.out_ready = 1'b1;
    wait_done("s5a", dbase);
    chk("s5_count_a", 32'(sym_q.size() - base), 32'd1);
    if (sym_q.size() > base) chk("s5_sym_busy_write", 32'(sym_q[base]), 32'd5);
    cfg_write(2'd3, 4'd0, 8'd7);
    base  = sym_q.size();
    dbase = done_total;
    send("s5_w1", 8'h00, 1'b1, 4'd1);
    wait_done("s5b", dbase);
    chk("s5_count_b", 32'(sym_q.size() - base), 32'd1);
    if (sym_q.size() > base) chk("s5_sym_idle_write", 32'(sym_q[base]), 32'd7);

    // Illegal code 11
    base  = sym_q.size();
    dbase = done_total;
    send("s2_w0", 8'hFF, 1'b1, 4'd2);
    wait_err(30);
    step(5);
    chk("s2_err",       32'(bus.err),       32'd1);
    chk("s2_in_ready",  32'(bus.in_ready),  32'd0);
    chk("s2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("s2_no_sym",    32'(sym_q.size() - base), 32'd0);
    chk("s2_no_done",   32'(done_total - dbase),  32'd0);

    // Only reset clears err
    rst = 1'b0;
    #1;
    check_reset_outputs("s2_reset");
    step(1);
    rst = 1'b1;
    step(2);
    load_table(8'd5);

    // Reset in the middle of the nominal stream
    send("s6_w0", 8'h5B, 1'b0, 4'd0);
    step(2);
    chk("s6_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("s6_reset");
    step(2);
    rst = 1'b1;
    step(2);
    base  = sym_q.size();
    dbase = done_total;
    send("s6_w1", 8'h80, 1'b1, 4'd2);
    wait_err(30);
    step(3);
    chk("s6_err",     32'(bus.err),             32'd1);
    chk("s6_no_sym",  32'(sym_q.size() - base), 32'd0);
    chk("s6_no_done", 32'(done_total - dbase),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/huffman_stream_decoder.md
# huffman_stream_decoder

Parametrised canonical-Huffman stream decoder. It replaces the fixed-table, fixed-width decoder in the decode path. It accepts MSB-first packed code words through a valid/ready input and keeps them in a bit buffer. It decodes variable-length codes against a runtime-programmable canonical table and emits one symbol per handshake on a valid/ready output. Stream end, exact bit count and illegal codes are reported explicitly.

## Interface
- IN_W, 8: input word width in bits; must be ≥ MAX_LEN.
- MAX_LEN, 8: longest code length; must be ≥ SYM_W+1 and ≤ 2^SYM_W.
- SYM_W, 4: symbol width; the symbol table has 2^SYM_W entries.
- Derived: BUF_W = IN_W+MAX_LEN; LEN_W = $clog2(MAX_LEN+1); NB_W = $clog2(IN_W+1).

Ports, clock and reset first:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- in_data, input, IN_W: code bits, MSB first.
- in_valid, input, 1: in_data is valid.
- in_last, input, 1: this word ends the stream.
- in_nbits, input, NB_W: valid bits in the last word, left-justified. Only sampled when in_last=1. A value of 0 is treated as IN_W.
- in_ready, output, 1: the block can accept a word.
- out_sym, output, SYM_W: decoded symbol.
- out_len, output, LEN_W: code length of out_sym.
- out_valid, output, 1: out_sym/out_len are valid.
- out_ready, input, 1: downstream accepts the symbol.
- done, output, 1: one-cycle pulse when the stream is fully consumed.
- err, output, 1: sticky illegal-code flag.
- busy, output, 1: high when fill≠0, or out_valid, or last_seen, or search is active.
- cfg_we, input, 1: table write strobe.
- cfg_sel, input, 2: selects the table. 0 = first_code, 1 = count, 2 = base, 3 = symbol.
- cfg_addr, input, SYM_W: address. For cfg_sel 0–2 the address is length−1; for cfg_sel 3 it is the symbol index.
- cfg_data, input, MAX_LEN: write data, truncated to the target table width.

## Operation
- **Tables, per length L = 1..MAX_LEN:**
  - first_code[L]: MAX_LEN bits.
  - count[L]: SYM_W+1 bits.
  - base[L]: SYM_W bits.
  - sym[i]: SYM_W bits.
- **Table writes:** applied only when busy=0; a write while busy=1 is ignored. Reset clears all tables to 0, so no code matches.
- **Bit buffer:** buf[BUF_W-1:0] is left-aligned, with a fill counter (0..BUF_W).
  - in_ready = !err && !last_seen && fill ≤ MAX_LEN.
  - On an accepted word, the word is appended at bit position BUF_W-1-fill and fill increases by IN_W, or by in_nbits for the last word.
  - in_last sets last_seen.
- **Lookup permitted** when all of the following hold: !err; (out_valid=0 or out_ready=1); fill>0; (fill ≥ MAX_LEN or last_seen).
- **Length check:** code_L = buf[BUF_W-1 -: L]. Length L matches when all of the following hold:
  - L ≤ fill;
  - count[L] ≠ 0;
  - code_L ≥ first_code[L];
  - code_L − first_code[L] < count[L].
- **Output on match:** sym[(base[L] + code_L − first_code[L]) mod 2^SYM_W] is registered to out_sym, L to out_len, and out_valid is set. The buffer shifts left by L and fill decreases by L.
- **Search order:** the smallest matching L wins.
- **Serial state machine** (SEARCH, with register cur_L):
  - Each permitted cycle checks cur_L.
  - On a match, cur_L returns to 1.
  - With no match and cur_L < MAX_LEN and cur_L < fill, cur_L increments.
  - Otherwise the machine enters ERROR.
  - If a lookup stalls because out_valid is high and out_ready is low, cur_L is held.
- **ERROR state:** err=1, in_ready=0, no further output. The symbol already pending in the output register still completes its handshake. Only reset exits ERROR.
- **End of stream:** when last_seen, fill=0 and out_valid=0 (or the final symbol's handshake completes), done pulses for 1 cycle and last_seen clears. The block then accepts a new stream.
- **Simultaneous consume and append:** the shift by L is applied first, and the new word is appended at the post-shift fill.
- **Simultaneous output handshake and new match:** out_sym is replaced with no bubble.

## Timing
- **Reset values:**
  - out_valid=0, out_sym=0, out_len=0, done=0, err=0, busy=0.
  - in_ready=1.
  - fill=0, cur_L=1, last_seen=0.
- **Reset mid-stream:** buffered bits, pending symbol and tables are discarded immediately.
- **Serial latency:** a code of length L sets out_valid L cycles after the first permitted cycle. Throughput is one symbol per L cycles.
- **Parallel latency:** 1 cycle. Throughput is one symbol per cycle.
- **Output stability:** out_sym and out_len are held stable while out_valid=1 and out_ready=0.
- **Combinational paths:** in_ready is a function of registers only. No combinational path from in_valid or out_ready to any output.

## Configuration
- HUFF_PARALLEL_EN defined: all MAX_LEN lengths are checked in one cycle with a priority encoder for the smallest match. cur_L is unused. ERROR is entered in the same cycle when no L ≤ min(fill, MAX_LEN) matches.
- HUFF_PARALLEL_EN undefined: the serial one-length-per-cycle search described above. Decoded symbols, error detection and done behaviour are identical in both builds; only cycle counts differ.

## Test plan
The first four scenarios use this table: codes 0/10/110/111 map to sym 5/9/3/12. Table contents: L1 first=0 cnt=1 base=0; L2 first=2 cnt=1 base=1; L3 first=6 cnt=2 base=2; sym[0..3] = 5, 9, 3, 12.

1. **Nominal decode:** send 0x5B, then 0x80 with last and nbits=2, out_ready=1 → symbols 5, 9, 3, 12, 5 with lengths 1, 2, 3, 3, 1, then done pulses once; err=0.
2. **Illegal code:** send 0xFF with last and nbits=2 → err rises and stays high; in_ready=0; no symbol is output; done is not pulsed.
3. **Backpressure:** scenario 1 with out_ready low for 5 cycles after the first out_valid → out_sym=5 is held stable; the sequence completes unchanged, with no loss or duplication.
4. **Latency check:** on the serial build, code 111 → out_valid 3 cycles after the lookup starts. On the HUFF_PARALLEL_EN build → 1 cycle.
5. **Config gating:** a cfg write of sym[0]=7 while busy=1 is ignored, and output is still 5. After done, the same write takes effect and the next stream outputs 7.
6. **Reset mid-stream:** assert rst in the middle of scenario 1 → all outputs return to their reset values immediately. A zero table then produces err on the next stream.
